// File: rtl/sbqm_pkg.sv
// Shared types and constants for the bank-queue sequencing controller.
// Holds the FSM encoding, the service-time factor and the wait-time width helper.
package sbqm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_DONE
  } sbqm_state_e;

  localparam int SERVICE_MIN = 3;

  // Wait time of "no teller on duty"; callers slice it to their Wtime width.
  localparam logic [31:0] WTIME_NO_TELLER = '1;

  function automatic int wtime_w(input int n);
    return n + 2;
  endfunction

endpackage

// File: rtl/sbqm_wait_div.sv
// Sequential restoring divider: W-bit dividend by 2-bit divisor, one quotient
// bit per cycle MSB first; done_o is high during the cycle of the last step.
module sbqm_wait_div
  import sbqm_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [1:0]   divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] quotient_o
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [1:0]    rem_q;
  logic [1:0]    dvs_q;
  logic [W-1:0]  dq_q;
  logic [2:0]    trial;
  logic [2:0]    diff;
  logic          ge;

  // Dividend bits shift out of dq_q while quotient bits shift in behind them.
  assign trial = {rem_q, dq_q[W-1]};
  assign diff  = trial - {1'b0, dvs_q};
  assign ge    = (trial >= {1'b0, dvs_q});

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(W - 1);
    end else if (busy_q) begin
      if (cnt_q == '0) busy_q <= 1'b0;
      else             cnt_q  <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (start_i) begin
      dq_q  <= dividend_i;
      rem_q <= 2'b00;
      dvs_q <= divisor_i;
    end else if (busy_q) begin
      dq_q  <= {dq_q[W-2:0], ge};
      rem_q <= ge ? diff[1:0] : trial[1:0];
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = busy_q & (cnt_q == '0);
  assign quotient_o = dq_q;

endmodule

// File: rtl/sbqm_queue_ctrl.sv
// Bank-queue sequencing controller: photocell edge detect, saturating occupancy
// count and a wait-time recompute FSM wrapped around the restoring divider.
module sbqm_queue_ctrl
  import sbqm_pkg::*;
#(
  parameter int N = 3,
  parameter int W = wtime_w(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         photo_a,
  input  logic         photo_b,
  input  logic [1:0]   tcount,
  output logic [N-1:0] Pcount,
  output logic [W-1:0] Wtime,
  output logic         wtime_valid,
  output logic         enter_reject,
  output logic         exit_error
);

  localparam logic [N-1:0] P_FULL = '1;

  logic        pa_q, pb_q, ev_a, ev_b;
  logic [N-1:0] pcount_q, pcount_d;
  logic        chg_q, rej_q, rej_d, err_q, err_d;
  logic [1:0]  tcount_q, tcount_d;
  sbqm_state_e state_q, state_d;
  logic        pend_q, pend_d, pend_any;
  logic [W-1:0] wtime_q, wtime_d, res_q, res_d, dividend, sum_w;
  logic        vld_q, vld_d, use_div_q, use_div_d;
  logic        trigger, div_start, div_busy, div_done;
  logic [W-1:0] div_quo;

  assign ev_a = pa_q & ~photo_a;
  assign ev_b = pb_q & ~photo_b;

  always_comb begin
    pcount_d = pcount_q;
    rej_d    = 1'b0;
    err_d    = 1'b0;
    if (ev_a && !ev_b) begin
      if (pcount_q != P_FULL) pcount_d = pcount_q + N'(1);
      else                    rej_d    = 1'b1;
    end else if (ev_b && !ev_a) begin
      if (pcount_q != '0) pcount_d = pcount_q - N'(1);
      else                err_d    = 1'b1;
    end
  end

  assign trigger  = chg_q | (tcount != tcount_q);
  assign pend_any = pend_q | trigger;
  assign sum_w    = W'(pcount_q) + W'(tcount) - W'(1);
  assign dividend = sum_w * W'(SERVICE_MIN);

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    tcount_d  = tcount_q;
    wtime_d   = wtime_q;
    vld_d     = vld_q;
    res_d     = res_q;
    use_div_d = use_div_q;
    div_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_any) begin
          vld_d    = 1'b0;
          pend_d   = 1'b0;
          tcount_d = tcount;
          if (tcount == 2'd0) begin
            res_d     = WTIME_NO_TELLER[W-1:0];
            use_div_d = 1'b0;
            state_d   = ST_DONE;
          end else if (pcount_q == '0) begin
            res_d     = '0;
            use_div_d = 1'b0;
            state_d   = ST_DONE;
          end else begin
            div_start = ~div_busy;
            use_div_d = 1'b1;
            state_d   = ST_DIV;
          end
        end
      end
      ST_DIV: begin
        if (trigger) begin
          pend_d   = 1'b1;
          tcount_d = tcount;
        end
        if (div_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        // A trigger arriving now still lands in pending; the result is kept
        // but not flagged valid until the follow-up recompute completes.
        if (trigger) tcount_d = tcount;
        wtime_d = use_div_q ? div_quo : res_q;
        vld_d   = ~pend_any;
        pend_d  = pend_any;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pa_q     <= 1'b0;
      pb_q     <= 1'b0;
      pcount_q <= '0;
      chg_q    <= 1'b0;
      rej_q    <= 1'b0;
      err_q    <= 1'b0;
      tcount_q <= tcount;
      state_q  <= ST_IDLE;
      pend_q   <= 1'b0;
      wtime_q  <= '0;
      vld_q    <= 1'b1;
    end else begin
      pa_q     <= photo_a;
      pb_q     <= photo_b;
      pcount_q <= pcount_d;
      chg_q    <= (pcount_d != pcount_q);
      rej_q    <= rej_d;
      err_q    <= err_d;
      tcount_q <= tcount_d;
      state_q  <= state_d;
      pend_q   <= pend_d;
      wtime_q  <= wtime_d;
      vld_q    <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    res_q     <= res_d;
    use_div_q <= use_div_d;
  end

  sbqm_wait_div #(.W(W)) u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (div_start),
    .dividend_i (dividend),
    .divisor_i  (tcount),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  assign Pcount       = pcount_q;
  assign Wtime        = wtime_q;
  assign wtime_valid  = vld_q;
  assign enter_reject = rej_q;
  assign exit_error   = err_q;

endmodule

// File: tb/tb_sbqm_queue_ctrl.sv
// Bench for sbqm_queue_ctrl: directed scenarios plus randomized photocell and
// teller activity, all checked each cycle against a behavioural queue model.
module tb_sbqm_queue_ctrl;

  localparam int N = 3;
  localparam int W = 5;
  localparam int PMAX = (1 << N) - 1;
  localparam int WONES = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         photo_a = 1'b0;
  logic         photo_b = 1'b0;
  logic [1:0]   tcount = 2'd2;
  logic [N-1:0] Pcount;
  logic [W-1:0] Wtime;
  logic         wtime_valid, enter_reject, exit_error;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_p = 0, m_tc = 2, m_stable = 0;
  bit m_rej = 0, m_err = 0, m_pa = 0, m_pb = 0, m_pchg = 0, m_post_rst = 1;

  sbqm_queue_ctrl #(.N(N), .W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .photo_a      (photo_a),
    .photo_b      (photo_b),
    .tcount       (tcount),
    .Pcount       (Pcount),
    .Wtime        (Wtime),
    .wtime_valid  (wtime_valid),
    .enter_reject (enter_reject),
    .exit_error   (exit_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_wtime(input int p, input int t);
    if (t == 0) return WONES;
    if (p == 0) return 0;
    return (3 * (p + t - 1)) / t;
  endfunction

  // One clock: advance the model at the edge, compare at the following negedge.
  task automatic tick();
    int  tc, oldp;
    bit  ea, eb;
    @(posedge clk);
    tc = int'(tcount);
    if (reset) begin
      m_p = 0; m_rej = 0; m_err = 0; m_pa = 0; m_pb = 0;
      m_pchg = 0; m_post_rst = 1; m_stable = 0; m_tc = tc;
    end else begin
      ea = m_pa & ~photo_a;
      eb = m_pb & ~photo_b;
      m_rej = 0; m_err = 0; oldp = m_p;
      if (ea && !eb) begin
        if (m_p < PMAX) m_p++; else m_rej = 1;
      end else if (eb && !ea) begin
        if (m_p > 0) m_p--; else m_err = 1;
      end
      m_pa = photo_a; m_pb = photo_b;
      m_pchg = (m_p != oldp);
      if (m_pchg || tc != m_tc) begin
        m_post_rst = 0;
        m_stable = 0;
      end else if (m_stable < 1000) begin
        m_stable++;
      end
      m_tc = tc;
    end
    @(negedge clk);
    check("pcount", int'(Pcount), m_p);
    check("enter_reject", int'(enter_reject), int'(m_rej));
    check("exit_error", int'(exit_error), int'(m_err));
    if (wtime_valid && !m_pchg)
      check("wtime", int'(Wtime), m_post_rst ? 0 : exp_wtime(m_p, m_tc));
    if (m_stable >= 20) check("valid_settled", int'(wtime_valid), 1);
  endtask

  task automatic fall_a();
    photo_a = 1'b1; repeat (3) tick();
    photo_a = 1'b0; tick();
  endtask

  task automatic fall_b();
    photo_b = 1'b1; repeat (3) tick();
    photo_b = 1'b0; tick();
  endtask

  task automatic fall_ab();
    photo_a = 1'b1; photo_b = 1'b1; repeat (3) tick();
    photo_a = 1'b0; photo_b = 1'b0; tick();
  endtask

  task automatic expect_latency(input int lat, input int wt);
    for (int i = 1; i < lat; i++) begin
      tick();
      check("lat_busy", int'(wtime_valid), 0);
    end
    tick();
    check("lat_valid", int'(wtime_valid), 1);
    check("lat_wtime", int'(Wtime), wt);
  endtask

  task automatic settle();
    repeat (20) tick();
    check("settle_valid", int'(wtime_valid), 1);
  endtask

  initial begin
    int seen;
    repeat (2) tick();
    check("rst_pcount", int'(Pcount), 0);
    check("rst_wtime", int'(Wtime), 0);
    check("rst_valid", int'(wtime_valid), 1);
    reset = 1'b0;
    tick();

    // Three arrivals with two tellers
    fall_a(); expect_latency(7, 3);
    fall_a(); expect_latency(7, 4);
    fall_a(); expect_latency(7, 6);

    // Fill with three tellers, overflow, then drop to one teller
    tcount = 2'd3;
    repeat (4) fall_a();
    settle();
    check("full_wtime", int'(Wtime), 9);
    fall_a();
    check("reject_pulse", int'(enter_reject), 1);
    check("reject_hold", int'(Pcount), 7);
    tick();
    check("reject_clear", int'(enter_reject), 0);
    tcount = 2'd1;
    expect_latency(7, 21);

    // Empty queue, underflow and simultaneous edges at both extremes
    repeat (7) fall_b();
    settle();
    check("empty_wtime", int'(Wtime), 0);
    fall_b();
    check("exit_err_pulse", int'(exit_error), 1);
    check("exit_err_hold", int'(Pcount), 0);
    tick();
    check("exit_err_clear", int'(exit_error), 0);
    fall_ab();
    check("both_empty", int'(Pcount), 0);
    check("both_empty_err", int'(exit_error), 0);
    repeat (7) fall_a();
    fall_ab();
    check("both_full", int'(Pcount), 7);
    check("both_full_rej", int'(enter_reject), 0);
    settle();

    // No teller shortcut and recovery
    repeat (3) fall_b();
    tcount = 2'd2;
    settle();
    tcount = 2'd0;
    expect_latency(2, WONES);
    tcount = 2'd2;
    expect_latency(7, 7);

    // Changes during an in-flight divide collapse into one recompute
    photo_a = 1'b1; photo_b = 1'b1; tick(); tick();
    photo_a = 1'b0; tick();        // Pcount 4 -> 5, divide starts
    tick(); tick();
    photo_b = 1'b0; tick();        // Pcount 5 -> 4 mid divide
    tick();
    tcount = 2'd3;                 // second trigger one cycle later
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (wtime_valid) seen = 1;
    end
    check("pend_reached", seen, 1);
    check("pend_wtime", int'(Wtime), exp_wtime(4, 3));

    // Reset in the middle of a divide
    fall_a();                      // Pcount 5
    repeat (3) tick();
    reset = 1'b1; tick();
    check("mid_rst_pcount", int'(Pcount), 0);
    check("mid_rst_wtime", int'(Wtime), 0);
    check("mid_rst_valid", int'(wtime_valid), 1);
    check("mid_rst_pulses", int'(enter_reject) + int'(exit_error), 0);
    reset = 1'b0;
    fall_a(); expect_latency(7, exp_wtime(1, 3));

    // Randomized activity bursts followed by quiet windows
    for (int b = 0; b < 40; b++) begin
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(0, 3) == 0) photo_a = ~photo_a;
        if ($urandom_range(0, 3) == 0) photo_b = ~photo_b;
        if ($urandom_range(0, 31) == 0) tcount = 2'($urandom_range(0, 3));
        reset = ($urandom_range(0, 499) == 0);
        tick();
      end
      reset = 1'b0;
      repeat (25) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sbqm_queue_ctrl.md
Name: sbqm_queue_ctrl

Overview:
- Sequencing controller for the bank-queue datapath.
- Converts entry/exit photocell levels into single-cycle person events and maintains the saturating occupancy count Pcount, which feeds the queue status flag block.
- Computes estimated wait time Wtime = 3*(Pcount + Tcount - 1)/Tcount with a sequential restoring divider.
- Sits between the sensor front-end and the display/status logic.

Parameters:
- N, 3, Pcount width; queue capacity 2^N-1.
- W, N+2, Wtime width; holds max 3*(2^N+1) for N>=2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset; single clock domain (clk).
- photo_a  input  1  entry photocell level, 1 = beam blocked.
- photo_b  input  1  exit (to-teller) photocell level, 1 = beam blocked.
- tcount  input  2  active tellers, 0..3.
- Pcount  output  N  persons in queue.
- Wtime  output  W  estimated wait time, integer quotient.
- wtime_valid  output  1  Wtime is current for present Pcount/tcount.
- enter_reject  output  1  one-cycle pulse: entry dropped, queue full.
- exit_error  output  1  one-cycle pulse: exit seen while queue empty.

Behaviour:
- Reset values: Pcount=0, Wtime=0, wtime_valid=1, enter_reject=0, exit_error=0, FSM=IDLE, pending=0, photo_a_q=photo_b_q=0, tcount_q<=tcount.
- Event detection: ev_a = photo_a_q & ~photo_a, a falling edge (person has passed). ev_b is defined the same way on photo_b. Edge registers update every cycle.
- Count update, registered at the edge where the event is seen (edge k):
  - ev_a only, Pcount<2^N-1: Pcount+1.
  - ev_a only, Pcount full: Pcount unchanged, enter_reject=1 for one cycle.
  - ev_b only, Pcount>0: Pcount-1.
  - ev_b only, Pcount==0: Pcount unchanged, exit_error=1 for one cycle.
  - ev_a and ev_b together: Pcount unchanged (net zero, valid at full and at empty), no pulses.
  - No wrap-around in either direction.
- Recompute trigger: Pcount changed at previous edge, or tcount != tcount_q. tcount_q is updated whenever a trigger is accepted.
- FSM states IDLE, DIV, DONE:
  - IDLE + trigger: wtime_valid<=0.
    - tcount==0: Wtime result = all ones (no service). Go to DONE.
    - Pcount==0: result = 0. Go to DONE.
    - Otherwise: load dividend = 3*(Pcount+tcount-1) (W bits), divisor = tcount, remainder = 0, bit counter = W-1. Go to DIV.
  - DIV: one restoring quotient bit per cycle, MSB first. After W cycles go to DONE.
  - DONE: Wtime<=quotient (or shortcut value), wtime_valid<=1. If pending, clear pending and re-enter as an IDLE trigger next cycle; else go to IDLE.
- Latency, counting from the Pcount update at edge k:
  - Divide path: wtime_valid=0 from edge k+1; Wtime/valid written at edge k+W+2 (7 cycles for N=3).
  - Shortcut path: Wtime/valid written at edge k+2.
- Trigger while in DIV/DONE: set pending; the in-flight result is still written but wtime_valid stays 0 until the pending recompute finishes. Multiple triggers collapse into one pending.
- Wtime holds its last value while wtime_valid=0.
- reset asserted in any state, including mid-DIV, returns all outputs and state to reset values at that edge. No partial result is written.
- Division arithmetic: unsigned, quotient truncated, remainder discarded. Divisor is never 0 on the divide path.

Decomposition:
- Package sbqm_pkg:
  - FSM state encoding (IDLE/DIV/DONE).
  - Constant SERVICE_MIN=3.
  - Function for wait-time width from N.
  - Constant for the "no teller" Wtime value (all ones).
- Sub-module sbqm_wait_div: sequential restoring divider with start/busy/done and W-bit dividend/quotient, 2-bit divisor.
- Top contains edge detect, saturating counter, trigger/pending logic and the FSM wrapper.
- Flags block is instantiated alongside by the integrator and driven from Pcount.

Test Plan:
- reset, tcount=2, three clean photo_a pulses (1 for 3 cycles, then 0) -> Pcount 1,2,3; final Wtime=6, valid=1 at 7 cycles after last update.
- Fill to Pcount=7 with tcount=3 -> Wtime=9; one more photo_a pulse -> enter_reject one cycle, Pcount stays 7; change tcount to 1 -> Wtime=21.
- Pcount=0, photo_b pulse -> exit_error one cycle, Pcount=0, Wtime=0; simultaneous photo_a/photo_b falling edges at Pcount=0 and at 7 -> Pcount unchanged, no pulses.
- tcount=0 with Pcount=4 -> Wtime=31 (all ones) at k+2; tcount back to 2 -> Wtime=7.
- Pcount change at DIV cycle 2, followed by a second change one cycle later -> single pending recompute; valid stays 0 until final Wtime matches last Pcount.
- Assert reset mid-DIV with Pcount=5 -> next edge Pcount=0, Wtime=0, valid=1, no pulses, FSM IDLE.
